// File: rtl/vproc_elem_seq_pkg.sv
// ---------------------------------------------------------------------------
// vproc_elem_seq_pkg
// Shared types and helpers for the ELEM instruction sequencer.
//   elem_op_t         ELEM unit operations, including the internal FLUSH phase
//   vsew_t            element width encoding (log2 of element bytes)
//   emul_t            register group multiplier encoding (log2 of registers)
//   elem_seq_state_t  sequencer FSM states
//   elem_seq_n_elem   element beats for one instruction (eew, emul, VREG_W)
//   elem_seq_n_flush  32-bit word beats of the flush phase (emul, VREG_W)
//   elem_seq_needs_flush  true for ops that append a flush phase
// ---------------------------------------------------------------------------
package vproc_elem_seq_pkg;

   typedef enum logic [3:0] {
      ELEM_XMV       = 4'd0,
      ELEM_VPOPC     = 4'd1,
      ELEM_VFIRST    = 4'd2,
      ELEM_VID       = 4'd3,
      ELEM_VIOTA     = 4'd4,
      ELEM_VRGATHER  = 4'd5,
      ELEM_VCOMPRESS = 4'd6,
      ELEM_FLUSH     = 4'd7,
      ELEM_VREDSUM   = 4'd8,
      ELEM_VREDAND   = 4'd9,
      ELEM_VREDOR    = 4'd10,
      ELEM_VREDXOR   = 4'd11,
      ELEM_VREDMINU  = 4'd12,
      ELEM_VREDMIN   = 4'd13,
      ELEM_VREDMAXU  = 4'd14,
      ELEM_VREDMAX   = 4'd15
   } elem_op_t;

   typedef enum logic [1:0] {
      VSEW_8   = 2'd0,
      VSEW_16  = 2'd1,
      VSEW_32  = 2'd2,
      VSEW_INV = 2'd3
   } vsew_t;

   typedef enum logic [1:0] {
      EMUL_1 = 2'd0,
      EMUL_2 = 2'd1,
      EMUL_4 = 2'd2,
      EMUL_8 = 2'd3
   } emul_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      GATHER = 2'd2,
      FLUSH  = 2'd3
   } elem_seq_state_t;

   // Elements in the register group: bytes per register scaled down by the
   // element size and up by the group multiplier (both log2 encoded).
   function automatic int unsigned elem_seq_n_elem(vsew_t eew, emul_t emul, int unsigned vreg_w);
      return ((vreg_w / 8) >> eew) << emul;
   endfunction

   // The flush phase always walks 32-bit words regardless of element width.
   function automatic int unsigned elem_seq_n_flush(emul_t emul, int unsigned vreg_w);
      return (vreg_w / 32) << emul;
   endfunction

   // Compress and every reduction leave partial results that must be drained.
   function automatic logic elem_seq_needs_flush(elem_op_t op);
      return (op inside {ELEM_VCOMPRESS, ELEM_VREDSUM, ELEM_VREDAND, ELEM_VREDOR,
                         ELEM_VREDXOR, ELEM_VREDMINU, ELEM_VREDMIN,
                         ELEM_VREDMAXU, ELEM_VREDMAX});
   endfunction

endpackage

// File: rtl/vproc_elem_seq_cnt.sv
// ---------------------------------------------------------------------------
// vproc_elem_seq_cnt
// Nested element-index / aux counter for the ELEM sequencer. The aux counter
// is the inner loop (only active when aux_en is set) and wraps back to zero
// while the index steps forward.
//   clk_i, async_rst_i  clock and asynchronous active-high reset
//   clear               synchronous return of both counters to zero
//   step                advance by one beat (ignored while clear is set)
//   aux_en              enable the inner aux loop (GATHER)
//   idx_term            final index value of the current phase
//   idx, aux            current counter values
//   last                counter sits on the final beat of the phase
// ---------------------------------------------------------------------------
module vproc_elem_seq_cnt #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned AUX_W = 2
) (
   input  logic             clk_i,
   input  logic             async_rst_i,
   input  logic             clear,
   input  logic             step,
   input  logic             aux_en,
   input  logic [CNT_W-1:0] idx_term,
   output logic [CNT_W-1:0] idx,
   output logic [AUX_W-1:0] aux,
   output logic             last
);

   logic aux_wrap;

   // Without the inner loop every beat counts as the end of an aux sweep, so
   // the index advances on each step and aux stays parked at zero.
   assign aux_wrap = ~aux_en | (aux == '1);
   assign last     = (idx == idx_term) & aux_wrap;

   // Clear takes priority so a phase change and the handshake that causes it
   // land both counters on zero for the first beat of the new phase.
   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         idx <= '0;
         aux <= '0;
      end else if (clear) begin
         idx <= '0;
         aux <= '0;
      end else if (step) begin
         if (aux_wrap) begin
            aux <= '0;
            idx <= idx + 1'b1;
         end else begin
            aux <= aux + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vproc_elem_seq.sv
// ---------------------------------------------------------------------------
// vproc_elem_seq
// Instruction sequencer for the ELEM unit. Accepts one decoded instruction
// and emits the beat stream (index, aux, first/last and tail flags) consumed
// by the ELEM operand-fetch stage, appending a flush phase for compress and
// reductions.
//   clk_i, async_rst_i            clock, asynchronous active-high reset
//   instr_valid_i/instr_ready_o   instruction handshake (ready while idle)
//   instr_op_i/eew_i/emul_i/vl_i  decoded instruction fields
//   beat_valid_o/beat_ready_i     beat handshake
//   beat_*_o                      beat fields, stable while stalled
//   busy_o                        an instruction is in flight
//   done_o                        one-cycle pulse after the final handshake
// ---------------------------------------------------------------------------
module vproc_elem_seq
   import vproc_elem_seq_pkg::*;
#(
   parameter int unsigned VREG_W      = 128,
   parameter int unsigned GATHER_OP_W = 32,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned AUX_W       = $clog2(VREG_W / GATHER_OP_W)
) (
   input  logic             clk_i,
   input  logic             async_rst_i,
   input  logic             instr_valid_i,
   output logic             instr_ready_o,
   input  elem_op_t         instr_op_i,
   input  vsew_t            instr_eew_i,
   input  emul_t            instr_emul_i,
   input  logic [CNT_W-1:0] instr_vl_i,
   output logic             beat_valid_o,
   input  logic             beat_ready_i,
   output elem_op_t         beat_op_o,
   output vsew_t            beat_eew_o,
   output emul_t            beat_emul_o,
   output logic             beat_first_o,
   output logic             beat_last_o,
   output logic             beat_vl_part0_o,
   output logic             beat_vl0_o,
   output logic [CNT_W-1:0] beat_idx_o,
   output logic [AUX_W-1:0] beat_aux_o,
   output logic             busy_o,
   output logic             done_o
);

   elem_seq_state_t  state_q;
   elem_op_t         op_q;
   vsew_t            eew_q;
   emul_t            emul_q;
   logic [CNT_W-1:0] vl_q;
   logic [CNT_W-1:0] term_q;
   logic             vl0_q;
   logic             done_q;

   logic             accept;
   logic             beat_hs;
   logic             in_elem;
   logic             cnt_last;
   logic [CNT_W-1:0] cnt_idx;
   logic [AUX_W-1:0] cnt_aux;

   assign accept  = (state_q == IDLE) & instr_valid_i;
   assign beat_hs = beat_valid_o & beat_ready_i;
   assign in_elem = (state_q == RUN) | (state_q == GATHER);

   // Both counters restart whenever a phase begins: on instruction accept and
   // on the final handshake of a phase (entering FLUSH or returning to IDLE).
   vproc_elem_seq_cnt #(
      .CNT_W (CNT_W),
      .AUX_W (AUX_W)
   ) u_cnt (
      .clk_i       (clk_i),
      .async_rst_i (async_rst_i),
      .clear       (accept | (beat_hs & cnt_last)),
      .step        (beat_hs & ~cnt_last),
      .aux_en      (state_q == GATHER),
      .idx_term    (term_q),
      .idx         (cnt_idx),
      .aux         (cnt_aux),
      .last        (cnt_last)
   );

   // Sequencer FSM. The terminal index of each phase is precomputed into
   // term_q so the counter only needs an equality compare. XMV is a single
   // beat and therefore gets a terminal index of zero. done_q is a one-cycle
   // pulse that coincides with the return to IDLE, so the next instruction
   // can be accepted in the same cycle that done_o is seen.
   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         state_q <= IDLE;
         op_q    <= ELEM_XMV;
         eew_q   <= VSEW_8;
         emul_q  <= EMUL_1;
         vl_q    <= '0;
         term_q  <= '0;
         vl0_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (instr_valid_i) begin
                  op_q   <= instr_op_i;
                  eew_q  <= instr_eew_i;
                  emul_q <= instr_emul_i;
                  vl_q   <= instr_vl_i;
                  vl0_q  <= (instr_vl_i == '0);
                  term_q <= (instr_op_i == ELEM_XMV) ? '0 :
                            CNT_W'(elem_seq_n_elem(instr_eew_i, instr_emul_i, VREG_W) - 1);
                  state_q <= (instr_op_i == ELEM_VRGATHER) ? GATHER : RUN;
               end
            end
            RUN, GATHER: begin
               if (beat_hs && cnt_last) begin
                  if (elem_seq_needs_flush(op_q)) begin
                     term_q  <= CNT_W'(elem_seq_n_flush(emul_q, VREG_W) - 1);
                     state_q <= FLUSH;
                  end else begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (beat_hs && cnt_last) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Beat fields come straight from state, latched fields and counters, all
   // of which only move on a handshake, so they hold while stalled.
   assign instr_ready_o   = (state_q == IDLE);
   assign beat_valid_o    = (state_q != IDLE);
   assign busy_o          = beat_valid_o;
   assign done_o          = done_q;
   assign beat_op_o       = (state_q == FLUSH) ? ELEM_FLUSH : op_q;
   assign beat_eew_o      = eew_q;
   assign beat_emul_o     = emul_q;
   assign beat_first_o    = in_elem & (cnt_idx == '0) & (cnt_aux == '0);
   assign beat_last_o     = beat_valid_o & cnt_last;
   assign beat_vl_part0_o = in_elem & (cnt_idx >= vl_q);
   assign beat_vl0_o      = vl0_q;
   assign beat_idx_o      = cnt_idx;
   assign beat_aux_o      = cnt_aux;

endmodule

// File: tb/tb_vproc_elem_seq.sv
// ---------------------------------------------------------------------------
// tb_vproc_elem_seq
// Scoreboard bench for the ELEM sequencer. Each issued instruction expands
// into its expected beat list through a reference model; a monitor pops and
// compares on every beat handshake and tracks the done pulse.
// ---------------------------------------------------------------------------
module tb_vproc_elem_seq;
   import vproc_elem_seq_pkg::*;

   localparam int VREG_W      = 128;
   localparam int GATHER_OP_W = 32;
   localparam int CNT_W       = 16;
   localparam int AUX_W       = 2;

   typedef struct packed {
      elem_op_t         op;
      vsew_t            eew;
      emul_t            emul;
      logic             first;
      logic             last;
      logic             vl_part0;
      logic             vl0;
      logic [CNT_W-1:0] idx;
      logic [AUX_W-1:0] aux;
   } beat_t;

   typedef struct packed {
      logic  fin;
      beat_t beat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             instr_valid = 1'b0;
   logic             instr_ready;
   elem_op_t         instr_op = ELEM_XMV;
   vsew_t            instr_eew = VSEW_8;
   emul_t            instr_emul = EMUL_1;
   logic [CNT_W-1:0] instr_vl = '0;
   logic             beat_valid;
   logic             beat_ready = 1'b0;
   elem_op_t         beat_op;
   vsew_t            beat_eew;
   emul_t            beat_emul;
   logic             beat_first;
   logic             beat_last;
   logic             beat_vl_part0;
   logic             beat_vl0;
   logic [CNT_W-1:0] beat_idx;
   logic [AUX_W-1:0] beat_aux;
   logic             busy;
   logic             done;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 0;
   bit   done_next = 1'b0;

   vproc_elem_seq #(
      .VREG_W      (VREG_W),
      .GATHER_OP_W (GATHER_OP_W),
      .CNT_W       (CNT_W)
   ) dut (
      .clk_i           (clk),
      .async_rst_i     (rst),
      .instr_valid_i   (instr_valid),
      .instr_ready_o   (instr_ready),
      .instr_op_i      (instr_op),
      .instr_eew_i     (instr_eew),
      .instr_emul_i    (instr_emul),
      .instr_vl_i      (instr_vl),
      .beat_valid_o    (beat_valid),
      .beat_ready_i    (beat_ready),
      .beat_op_o       (beat_op),
      .beat_eew_o      (beat_eew),
      .beat_emul_o     (beat_emul),
      .beat_first_o    (beat_first),
      .beat_last_o     (beat_last),
      .beat_vl_part0_o (beat_vl_part0),
      .beat_vl0_o      (beat_vl0),
      .beat_idx_o      (beat_idx),
      .beat_aux_o      (beat_aux),
      .busy_o          (busy),
      .done_o          (done)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   function automatic bit needsFlush(elem_op_t op);
      case (op)
         ELEM_VCOMPRESS, ELEM_VREDSUM, ELEM_VREDAND, ELEM_VREDOR, ELEM_VREDXOR,
         ELEM_VREDMINU, ELEM_VREDMIN, ELEM_VREDMAXU, ELEM_VREDMAX: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Reference model: expand one instruction into its full list of beats.
   task automatic modelPush(input elem_op_t op, input vsew_t eew, input emul_t emul, input logic [CNT_W-1:0] vl);
      int    elem_bytes = 1 << int'(eew);
      int    regs = 1 << int'(emul);
      int    n_elem = ((VREG_W / 8) / elem_bytes) * regs;
      int    n_aux = (op == ELEM_VRGATHER) ? (VREG_W / GATHER_OP_W) : 1;
      int    n_flush = (VREG_W / 32) * regs;
      bit    fl = needsFlush(op);
      exp_t  e;
      if (op == ELEM_XMV) n_elem = 1;
      for (int i = 0; i < n_elem; i++) begin
         for (int a = 0; a < n_aux; a++) begin
            e.beat.op       = op;
            e.beat.eew      = eew;
            e.beat.emul     = emul;
            e.beat.first    = (i == 0) && (a == 0);
            e.beat.last     = (i == n_elem - 1) && (a == n_aux - 1);
            e.beat.vl_part0 = (i >= int'(vl));
            e.beat.vl0      = (vl == 0);
            e.beat.idx      = CNT_W'(i);
            e.beat.aux      = AUX_W'(a);
            e.fin           = e.beat.last && !fl;
            exp_q.push_back(e);
         end
      end
      if (fl) begin
         for (int w = 0; w < n_flush; w++) begin
            e.beat.op       = ELEM_FLUSH;
            e.beat.eew      = eew;
            e.beat.emul     = emul;
            e.beat.first    = 1'b0;
            e.beat.last     = (w == n_flush - 1);
            e.beat.vl_part0 = 1'b0;
            e.beat.vl0      = (vl == 0);
            e.beat.idx      = CNT_W'(w);
            e.beat.aux      = '0;
            e.fin           = e.beat.last;
            exp_q.push_back(e);
         end
      end
   endtask

   // Drive one instruction and hold it until accepted; reports whether
   // done_o was high in the accept cycle.
   task automatic applyStimulus(input elem_op_t op, input vsew_t eew, input emul_t emul,
                                input logic [CNT_W-1:0] vl, output bit saw_done);
      int guard = 0;
      modelPush(op, eew, emul, vl);
      instr_op    = op;
      instr_eew   = eew;
      instr_emul  = emul;
      instr_vl    = vl;
      instr_valid = 1'b1;
      do begin
         @(negedge clk);
         guard++;
      end while (!instr_ready && guard < 5000);
      if (!instr_ready) begin
         errors++;
         $display("[TB] FAIL accept_timeout: instr_ready %b expected 1", instr_ready);
      end
      saw_done = done;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int guard = 0;
      while ((exp_q.size() != 0 || busy) && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) begin
         errors++;
         $display("[TB] FAIL drain_timeout: %0d beats pending expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic waitBeat(input int idx, input bool_hs);
   endtask

   // Ready generator: random, forced low or forced high.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       beat_ready = ($urandom_range(0, 3) != 0);
         1:       beat_ready = 1'b0;
         default: beat_ready = 1'b1;
      endcase
   end

   // Monitor: at each falling edge, a valid&ready pair means a handshake at
   // the next rising edge; pop the expected beat and compare. done_o must
   // follow the final beat of an instruction by exactly one cycle.
   always @(negedge clk) begin
      exp_t  e;
      beat_t act;
      if (!rst) begin
         if (done || done_next) checkOutput("done_pulse", 64'(done), 64'(done_next));
         done_next = 1'b0;
         if (beat_valid && beat_ready) begin
            act = '{op: beat_op, eew: beat_eew, emul: beat_emul, first: beat_first,
                    last: beat_last, vl_part0: beat_vl_part0, vl0: beat_vl0,
                    idx: beat_idx, aux: beat_aux};
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_beat: got %h expected no beat", act);
            end else begin
               e = exp_q.pop_front();
               checkOutput("beat", 64'(act), 64'(e.beat));
               done_next = e.fin;
            end
         end
      end
   end

   // Watchdog so a stuck design still ends the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit    sd;
      int    guard;
      beat_t stall_exp;
      elem_op_t rop;

      // Reset state
      #2;
      checkOutput("rst_valid", 64'(beat_valid), 64'(0));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_done", 64'(done), 64'(0));
      checkOutput("rst_idx", 64'(beat_idx), 64'(0));
      checkOutput("rst_flags", 64'({beat_first, beat_last, beat_vl_part0, beat_vl0}), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_reset", 64'(instr_ready), 64'(1));
      @(posedge clk);
      #1;

      // Reduction with tail and flush
      applyStimulus(ELEM_VREDSUM, VSEW_32, EMUL_1, 16'd3, sd);
      waitIdle();

      // Gather inner loop
      applyStimulus(ELEM_VRGATHER, VSEW_8, EMUL_1, 16'd16, sd);
      waitIdle();

      // Single-beat move with vl = 0
      applyStimulus(ELEM_XMV, VSEW_32, EMUL_1, 16'd0, sd);
      waitIdle();

      // Backpressure: freeze at idx 5
      applyStimulus(ELEM_VID, VSEW_16, EMUL_2, 16'd10, sd);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!(beat_valid && beat_ready && beat_idx == 16'd4) && guard < 2000);
      ready_mode = 1;
      @(posedge clk);
      #1;
      stall_exp = '{op: ELEM_VID, eew: VSEW_16, emul: EMUL_2, first: 1'b0, last: 1'b0,
                    vl_part0: 1'b0, vl0: 1'b0, idx: 16'd5, aux: 2'd0};
      repeat (5) begin
         @(negedge clk);
         checkOutput("stall_valid", 64'(beat_valid), 64'(1));
         checkOutput("stall_fields", 64'({beat_op, beat_eew, beat_emul, beat_first, beat_last,
                                            beat_vl_part0, beat_vl0, beat_idx, beat_aux}),
                     64'(stall_exp));
      end
      ready_mode = 0;
      waitIdle();

      // Reset in the middle of an instruction
      ready_mode = 2;
      applyStimulus(ELEM_VIOTA, VSEW_8, EMUL_1, 16'd12, sd);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!(beat_valid && beat_idx == 16'd5) && guard < 2000);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst_valid", 64'(beat_valid), 64'(0));
      checkOutput("midrst_busy", 64'(busy), 64'(0));
      exp_q.delete();
      done_next = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_ready", 64'(instr_ready), 64'(1));
      checkOutput("midrst_no_done", 64'(done), 64'(0));
      ready_mode = 0;
      @(posedge clk);
      #1;
      applyStimulus(ELEM_VIOTA, VSEW_8, EMUL_1, 16'd5, sd);
      waitIdle();

      // Back-to-back: second accepted exactly in the done cycle
      applyStimulus(ELEM_VCOMPRESS, VSEW_32, EMUL_2, 16'd6, sd);
      applyStimulus(ELEM_VREDOR, VSEW_8, EMUL_1, 16'd9, sd);
      checkOutput("b2b_accept_in_done_cycle", 64'(sd), 64'(1));
      waitIdle();

      // Randomized instructions, sometimes issued back to back
      repeat (12) begin
         rop = elem_op_t'($urandom_range(0, 15));
         if (rop == ELEM_FLUSH) rop = ELEM_VPOPC;
         applyStimulus(rop, vsew_t'($urandom_range(0, 2)), emul_t'($urandom_range(0, 3)),
                       CNT_W'($urandom_range(0, 40)), sd);
         if ($urandom_range(0, 1) == 0) waitIdle();
      end
      waitIdle();
      checkOutput("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
